// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/DIV sequencer: shift-add multiplier and restoring divider, one writeback beat.
// Optional macro MULDIV_EARLY_EXIT_EN lets MUL finish once the remaining multiplier is zero.
module muldiv_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic [2:0]       rd_addr_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic [2:0]       rd_addr_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_wen_o,
  output logic             div_zero_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       rd_addr_q;
  logic             div_zero_q;

  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic             last_iter;

  // Divider step: the partial remainder never exceeds the divisor, so WIDTH+1 bits suffice.
  always_comb begin
    rem_shift = {rem_q, a_q[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, b_q});
  end

`ifdef MULDIV_EARLY_EXIT_EN
  always_comb begin
    last_iter = (cnt_q == LAST_CNT) || (!op_q && (b_q[WIDTH-1:1] == '0));
  end
`else
  always_comb begin
    last_iter = (cnt_q == LAST_CNT);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            op_q      <= op_i;
            a_q       <= op1_i;
            b_q       <= op2_i;
            rd_addr_q <= rd_addr_i;
            cnt_q     <= '0;
            rem_q     <= '0;
            // A zero divisor skips iteration and reports all-ones.
            if (op_i && (op2_i == '0)) begin
              acc_q      <= '1;
              div_zero_q <= 1'b1;
              state      <= DONE;
            end else begin
              acc_q      <= '0;
              div_zero_q <= 1'b0;
              state      <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (!op_q) begin
              if (b_q[0]) begin
                acc_q <= acc_q + a_q;
              end
              a_q <= a_q << 1;
              b_q <= b_q >> 1;
            end else begin
              if (rem_ge) begin
                rem_q <= WIDTH'(rem_shift - {1'b0, b_q});
              end else begin
                rem_q <= rem_shift[WIDTH-1:0];
              end
              acc_q <= {acc_q[WIDTH-2:0], rem_ge};
              a_q   <= a_q << 1;
            end
            if (last_iter) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o     = (state != IDLE);
  assign stall_o    = ((state == IDLE) && start_i && !flush_i) || (state == CALC);
  assign rd_wen_o   = (state == DONE);
  assign rd_data_o  = rd_wen_o ? acc_q : '0;
  assign rd_addr_o  = rd_wen_o ? rd_addr_q : 3'd0;
  assign div_zero_o = rd_wen_o & div_zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected writebacks, a monitor pops and compares.
// Expected latency follows MULDIV_EARLY_EXIT_EN when the bench is built with it.
module tb_muldiv_seq;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             start_i;
  logic             op_i;
  logic [WIDTH-1:0] op1_i;
  logic [WIDTH-1:0] op2_i;
  logic [2:0]       rd_addr_i;
  logic             flush_i;
  logic             busy_o;
  logic             stall_o;
  logic [2:0]       rd_addr_o;
  logic [WIDTH-1:0] rd_data_o;
  logic             rd_wen_o;
  logic             div_zero_o;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [2:0]       addr;
    logic             dz;
    int               exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   idle_pending = 0;

  muldiv_seq #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .op1_i      (op1_i),
    .op2_i      (op2_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .stall_o    (stall_o),
    .rd_addr_o  (rd_addr_o),
    .rd_data_o  (rd_data_o),
    .rd_wen_o   (rd_wen_o),
    .div_zero_o (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain unsigned arithmetic.
  function automatic logic [WIDTH-1:0] expResult(input logic op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    int unsigned ua, ub, p;
    ua = a;
    ub = b;
    if (op) begin
      if (ub == 0) return '1;
      return WIDTH'(ua / ub);
    end
    p = ua * ub;
    return p[WIDTH-1:0];
  endfunction

  function automatic int expLatency(input logic op, input logic [WIDTH-1:0] b);
    if (op && (b == '0)) return 1;
`ifdef MULDIV_EARLY_EXIT_EN
    if (!op) begin
      if (b == '0) return 2;
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (b[i]) return i + 2;
      end
    end
`endif
    return WIDTH + 1;
  endfunction

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy_o || (sb.size() != 0)) && (n < 200)) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle: busy=%0b pending=%0d", busy_o, sb.size());
    end
  endtask

  // Drives one request during cycle 0 and returns #1 into cycle 1.
  task automatic applyStimulus(input logic op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [2:0] addr);
    exp_t e;
    start_i   = 1'b1;
    op_i      = op;
    op1_i     = a;
    op2_i     = b;
    rd_addr_i = addr;
    e.data    = expResult(op, a, b);
    e.addr    = addr;
    e.dz      = op && (b == '0);
    e.exp_cyc = cyc + expLatency(op, b);
    sb.push_back(e);
    #1;
    checkOutput("stall_on_start", {31'd0, stall_o}, 32'd1);
    @(posedge clk);
    #1;
    start_i   = 1'b0;
    op1_i     = $urandom;
    op2_i     = $urandom;
    rd_addr_i = 3'($urandom);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    checkOutput({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    checkOutput({tag, "_wen"}, {31'd0, rd_wen_o}, 32'd0);
    checkOutput({tag, "_data"}, {16'd0, rd_data_o}, 32'd0);
    checkOutput({tag, "_addr"}, {29'd0, rd_addr_o}, 32'd0);
    checkOutput({tag, "_dz"}, {31'd0, div_zero_o}, 32'd0);
  endtask

  // Monitor: compares every writeback beat against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (idle_pending) begin
        checkOutput("busy_after_wb", {31'd0, busy_o}, 32'd0);
        idle_pending = 0;
      end
      if (rd_wen_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_wb: data %0h addr %0d with nothing pending", rd_data_o, rd_addr_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("wb_data", {16'd0, rd_data_o}, {16'd0, e.data});
          checkOutput("wb_addr", {29'd0, rd_addr_o}, {29'd0, e.addr});
          checkOutput("wb_div_zero", {31'd0, div_zero_o}, {31'd0, e.dz});
          checkOutput("wb_cycle", cyc, e.exp_cyc);
          checkOutput("stall_in_done", {31'd0, stall_o}, 32'd0);
          idle_pending = 1;
        end
      end else if ((sb.size() != 0) && (cyc > sb[0].exp_cyc)) begin
        checks++;
        errors++;
        $display("[TB] FAIL missing_wb: got no writeback expected one at cycle %0d", sb[0].exp_cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic             rop;
    logic [WIDTH-1:0] ra, rb;
    rst       = 1'b1;
    start_i   = 1'b0;
    op_i      = 1'b0;
    op1_i     = '0;
    op2_i     = '0;
    rd_addr_i = '0;
    flush_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] MUL 7x6 with stall window");
    applyStimulus(1'b0, 16'd7, 16'd6, 3'd3);
`ifndef MULDIV_EARLY_EXIT_EN
    for (int i = 1; i <= 16; i++) begin
      checkOutput("stall_calc", {31'd0, stall_o}, 32'd1);
      @(posedge clk);
      #1;
    end
`endif
    waitIdle();

    $display("[TB] directed divides");
    applyStimulus(1'b1, 16'd100, 16'd7, 3'd5);
    waitIdle();
    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 3'd1);
    waitIdle();
    applyStimulus(1'b1, 16'd9, 16'd0, 3'd2);
    waitIdle();

    $display("[TB] MUL 300x300 with ignored second start");
    applyStimulus(1'b0, 16'd300, 16'd300, 3'd4);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    start_i   = 1'b1;
    op_i      = 1'b1;
    op1_i     = 16'd9;
    op2_i     = 16'd0;
    rd_addr_i = 3'd1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    waitIdle();

    $display("[TB] early-exit candidates");
    applyStimulus(1'b0, 16'd3, 16'd5, 3'd6);
    waitIdle();
    applyStimulus(1'b0, 16'd3, 16'd0, 3'd7);
    waitIdle();

    $display("[TB] flush in CALC");
    applyStimulus(1'b0, 16'd1234, 16'hF0F1, 3'd6);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    flush_i = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    checkOutput("flush_busy", {31'd0, busy_o}, 32'd0);
    repeat (20) begin
      @(posedge clk);
      #1;
    end

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 16'd5000, 16'd3, 3'd2);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    checkResetOutputs("midrst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 16'd11, 16'd13, 3'd7);
    waitIdle();

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = WIDTH'($urandom_range(1, 15));
        default: rb = WIDTH'($urandom);
      endcase
      applyStimulus(rop, ra, rb, 3'($urandom));
      waitIdle();
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
